// File: rtl/nibble_add_scheduler_pkg.sv
// Shared definitions for the nibble-serial adder scheduler.
//   state_t  : scheduler FSM states (IDLE / RUN / DONE)
//   NIB_W    : width of the shared carry-lookahead slice
//   req_id_t : requester identifier (two requesters)
package nibble_add_scheduler_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [0:0] req_id_t;

endpackage

// File: rtl/nibble_add_scheduler_cla.sv
// nibble_cla_slice: purely combinational 4-bit generate/propagate adder slice.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   sum  : nibble sum
//   cout : carry out of bit 3
module nibble_cla_slice
  import nibble_add_scheduler_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] w_g;
  logic [NIB_W-1:0] w_p;
  logic [NIB_W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      w_c[i+1] = w_g[i] | (w_c[i] & w_p[i]);
    end
  end

  assign sum  = w_p ^ w_c[NIB_W-1:0];
  assign cout = w_c[NIB_W];

endmodule

// File: rtl/nibble_add_scheduler.sv
// nibble_add_scheduler: two-requester round-robin front end feeding one
// shared 4-bit adder slice that is stepped across the operand, LSB nibble
// first, one nibble per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready only in IDLE)
//   req_a0/b0, req_a1/b1 : operands of requester 0 / 1
//   req_cin              : per-requester carry-in
//   out_valid/out_ready  : result handshake, result held stable while stalled
//   out_sum, out_cout    : WIDTH-bit sum and carry out of bit WIDTH-1
//   out_id               : requester that owns the result
//   busy                 : high while an operation is in RUN or DONE
module nibble_add_scheduler
  import nibble_add_scheduler_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [0:0]       out_id,
  output logic             busy
);

  localparam int NIBS = WIDTH / NIB_W;
  localparam int K_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [K_W-1:0] LAST_K = K_W'(NIBS - 1);

  state_t           r_state;
  state_t           w_next;
  req_id_t          r_prio;
  req_id_t          r_id;
  logic [K_W-1:0]   r_k;
  logic             r_carry;
  logic             r_cout;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;

  logic [1:0]       w_ready;
  logic             w_accept;
  req_id_t          w_win;
  logic [NIB_W-1:0] w_nib_a;
  logic [NIB_W-1:0] w_nib_b;
  logic [NIB_W-1:0] w_nib_sum;
  logic             w_nib_cout;

  // Arbitration and next state. Ready is one-hot at most: a lone valid is
  // granted outright, contention goes to the requester favoured by r_prio.
  always_comb begin
    w_next  = r_state;
    w_ready = 2'b00;
    case (r_state)
      IDLE: begin
        w_ready[0] = req_valid[0] & (~req_valid[1] | (r_prio == 1'b0));
        w_ready[1] = req_valid[1] & (~req_valid[0] | (r_prio == 1'b1));
        if (|w_ready) w_next = RUN;
      end
      RUN:     if (r_k == LAST_K) w_next = DONE;
      DONE:    if (out_ready)     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = |w_ready;
  assign w_win    = w_ready[1];

  assign w_nib_a = r_a[r_k*NIB_W +: NIB_W];
  assign w_nib_b = r_b[r_k*NIB_W +: NIB_W];

  nibble_cla_slice u_slice (
    .a    (w_nib_a),
    .b    (w_nib_b),
    .cin  (r_carry),
    .sum  (w_nib_sum),
    .cout (w_nib_cout)
  );

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_id    <= 1'b0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id    <= w_win;
            r_prio  <= ~w_win;
            r_k     <= '0;
            r_carry <= w_win ? req_cin[1] : req_cin[0];
          end
        end
        RUN: begin
          r_sum[r_k*NIB_W +: NIB_W] <= w_nib_sum;
          r_carry                   <= w_nib_cout;
          if (r_k == LAST_K) begin
            r_cout <= w_nib_cout;
            r_k    <= '0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture: only the accepting edge loads, so later req_* changes
  // cannot disturb the running operation.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && w_accept) begin
      r_a <= w_win ? req_a1 : req_a0;
      r_b <= w_win ? req_b1 : req_b0;
    end
  end

  assign req_ready = w_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_id    = r_id;

endmodule

// File: tb/tb_nibble_add_scheduler.sv
module tb_nibble_add_scheduler;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]   req_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic [0:0]   out_id;
  logic         busy;

  nibble_add_scheduler #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_cin   (req_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } exp_t;

  exp_t sb_q[$];
  int   lat_q[$];
  int   m_prio = 0;     // reference round-robin pointer
  int   or_mode = 0;    // 0 random out_ready, 1 force low, 2 force high

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Downstream readiness
  always @(posedge clk) begin
    #1;
    case (or_mode)
      1:       out_ready = 1'b0;
      2:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor / scoreboard
  logic         prev_ov = 0, held = 0, prev_hs = 0;
  logic [W-1:0] h_sum;
  logic         h_cout;
  logic [0:0]   h_id;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 0; held = 0; prev_hs = 0;
    end else begin
      if (busy) chk("ready_low_when_busy", req_ready, 2'b00);
      if (prev_hs) begin
        chk("idle_after_handshake_valid", out_valid, 0);
        chk("idle_after_handshake_busy", busy, 0);
      end
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", cyc - lat_q.pop_front(), 4);
      end
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sum", out_sum, h_sum);
        chk("stall_cout", out_cout, h_cout);
        chk("stall_id", out_id, h_id);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("result_without_request", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sum", out_sum, e.sum);
          chk("cout", out_cout, e.cout);
          chk("id", out_id, e.id);
        end
      end
      held    = out_valid && !out_ready;
      prev_hs = out_valid && out_ready;
      prev_ov = out_valid;
      h_sum = out_sum; h_cout = out_cout; h_id = out_id;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  // Offer one request pattern; the model decides the winner and expected sum.
  task automatic issue(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] cin);
    int w;
    logic [W:0] full;
    exp_t e;
    wait_idle();
    req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1; req_cin = cin;
    #1;
    if (v == 2'b00) begin
      chk("ready_none", req_ready, 2'b00);
      @(posedge clk); #1;
      chk("no_grant_busy", busy, 0);
      return;
    end
    if (v == 2'b11) w = m_prio;
    else w = (v == 2'b10) ? 1 : 0;
    chk("grant", req_ready, (w == 1) ? 2'b10 : 2'b01);
    full  = (w == 1) ? ({1'b0, a1} + {1'b0, b1} + cin[1]) : ({1'b0, a0} + {1'b0, b0} + cin[0]);
    e.sum = full[W-1:0]; e.cout = full[W]; e.id = w[0];
    sb_q.push_back(e);
    m_prio = 1 - w;
    @(posedge clk); #1;
    lat_q.push_back(cyc);
    req_valid = 2'b00;
    // Scramble operands right after acceptance; the result must not change.
    req_a0 = W'($urandom); req_b0 = W'($urandom);
    req_a1 = W'($urandom); req_b1 = W'($urandom);
    req_cin = 2'($urandom);
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_cin = 0; out_ready = 1;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Contention from reset: req0, then req1, then req0 again
    issue(2'b11, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 2'b00);
    issue(2'b11, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 2'b00);
    issue(2'b11, 16'h0003, 16'h0004, 16'h1111, 16'h2222, 2'b00);
    // Single requester and carry ripple
    issue(2'b01, 16'h1234, 16'h4321, 16'h0, 16'h0, 2'b00);
    issue(2'b01, 16'hFFFF, 16'h0000, 16'h0, 16'h0, 2'b01);
    issue(2'b10, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 2'b10);
    issue(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);

    // Backpressure: hold out_ready low while DONE
    or_mode = 1;
    issue(2'b10, 16'h0, 16'h0, 16'hABCD, 16'h1234, 2'b10);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("bp_out_valid", out_valid, 1);
    end
    repeat (5) @(posedge clk);
    @(negedge clk) or_mode = 2;
    wait_idle();
    or_mode = 0;

    // Reset in the second RUN cycle discards the operation
    issue(2'b01, 16'h5A5A, 16'hA5A5, 16'h0, 16'h0, 2'b01);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    chk("mid_rst_out_cout", out_cout, 0);
    chk("mid_rst_out_id", out_id, 0);
    chk("mid_rst_busy", busy, 0);
    void'(sb_q.pop_back());
    void'(lat_q.pop_back());
    m_prio = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (8) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", out_valid, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [W-1:0] a0, b0;
      a0 = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
      b0 = W'($urandom);
      issue(2'($urandom), a0, b0, W'($urandom), W'($urandom), 2'($urandom));
    end

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
      chk("drain", sb_q.size(), 0);
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_add_scheduler.md
NIBBLE_ADD_SCHEDULER -- requirements
Module: nibble_add_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; a multiple of 4, minimum 4.
REQ-002 SHALL have ports, one per line:
 - clk  input  1  single clock; all state updates on rising edge.
 - rst_n  input  1  asynchronous, active-low reset.
 - req_valid  input  2  per-requester valid; bit r belongs to requester r.
 - req_ready  output  2  per-requester ready; at most one bit high.
 - req_a0, req_b0  input  WIDTH  requester 0 operands.
 - req_a1, req_b1  input  WIDTH  requester 1 operands.
 - req_cin  input  2  per-requester carry-in.
 - out_valid  output  1  result available.
 - out_ready  input  1  downstream accepts result.
 - out_sum  output  WIDTH  sum.
 - out_cout  output  1  carry out of bit WIDTH-1.
 - out_id  output  1  requester that owns the result.
 - busy  output  1  high in RUN or DONE.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL time-share one 4-bit carry-lookahead slice (g=a&b, p=a^b, s=p^c, c_next=g|(c&p)) across WIDTH/4 nibbles, LSB nibble first.
REQ-005 SHALL implement states IDLE, RUN, DONE.
REQ-006 IDLE: req_ready[r] = req_valid[r] & (~req_valid[1-r] | prio==r); combinational, IDLE only.
REQ-007 Accept = req_valid[r] & req_ready[r]; on the accepting edge SHALL latch operands, cin and id r, clear nibble index, enter RUN, and set prio to 1-r.
REQ-008 RUN: each cycle SHALL add nibble k with the carry held from nibble k-1 (req_cin for k=0), write sum bits [4k+3:4k], register the carry, and increment k.
REQ-009 After nibble WIDTH/4-1, SHALL enter DONE; out_valid rises exactly WIDTH/4 edges after the accepting edge (4 for WIDTH=16).
REQ-010 DONE: out_valid=1; out_sum, out_cout and out_id SHALL stay stable until out_valid & out_ready, then return to IDLE on that edge.
REQ-011 req_ready SHALL be 0 in RUN and DONE; the earliest next accept is the cycle after the output handshake (no bypass).
REQ-012 Operand changes on req_* after acceptance SHALL have no effect on the running operation.
REQ-013 Sum is modulo 2^WIDTH; out_cout = bit WIDTH of a+b+cin.
REQ-014 A single requester valid SHALL be granted regardless of prio; with both valid, the requester not served last wins (round-robin).
REQ-015 Valid deasserted in IDLE before grant SHALL not be an error; no state change.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, out_valid=0, out_sum=0, out_cout=0, out_id=0, busy=0, prio=0 (requester 0 wins first contention), and nibble index 0.
REQ-017 Reset during RUN or DONE SHALL discard the in-flight operation; no result is delivered after release.

Structure
REQ-018 Shared package SHALL hold the state enum (IDLE/RUN/DONE), NIB_W=4 and the requester-id type.
REQ-019 The 4-bit g/p slice SHALL be a sub-module, nibble_cla_slice (a[3:0], b[3:0], cin -> sum[3:0], cout), purely combinational.
REQ-020 FSM, arbiter, operand/result registers and carry register SHALL reside in nibble_add_scheduler.

Verification
REQ-021 Req0 only: a=0x1234, b=0x4321, cin=0 -> accept, out_valid 4 edges later, sum=0x5555, cout=0, id=0.
REQ-022 Carry ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 after 4 cycles.
REQ-023 Both valid from reset: req0 (0x0001+0x0001) then req1 (0x8000+0x8000) -> first result id=0 sum=0x0002; second id=1 sum=0x0000 cout=1; a third contention grants req0.
REQ-024 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_sum/out_id stable, req_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-025 Reset asserted in the 2nd RUN cycle -> all outputs 0 immediately; after release no out_valid until a new accept.
REQ-026 Operands changed in the cycle after accept -> result matches the originally latched operands.
